// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the memory controller, the load/store buffer and the
// decoder: access-type encodings, the IO address-space tag, the controller
// state type and a couple of small decode helpers.
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    // Access types (lsb_type). Bit 3 = store, bit 2 = unsigned load,
    // bits [1:0] = size (00 byte, 01 half, 10 word).
    localparam logic [3:0] LS_LB  = 4'b0000;
    localparam logic [3:0] LS_LH  = 4'b0001;
    localparam logic [3:0] LS_LW  = 4'b0010;
    localparam logic [3:0] LS_LBU = 4'b0100;
    localparam logic [3:0] LS_LHU = 4'b0101;
    localparam logic [3:0] LS_SB  = 4'b1000;
    localparam logic [3:0] LS_SH  = 4'b1001;
    localparam logic [3:0] LS_SW  = 4'b1010;

    // addr[17:16] value that selects the memory-mapped IO (UART) space
    localparam logic [1:0] IO_SPACE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_FETCH
    } state_e;

    // Number of bytes moved by an LSB access
    function automatic logic [2:0] ls_bytes(input logic [3:0] t);
        case (t[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [31:0] a);
        return a[17:16] == IO_SPACE;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// Bundles the LSB request port, the instruction-fetch port and the byte-wide
// RAM port of the memory controller.
//   slave  : the controller (takes requests, drives the RAM address/data)
//   master : the environment (LSB, fetch unit and RAM / IO buffer)
// -----------------------------------------------------------------------------
interface mem_ctrl_if;

    // LSB side
    logic        ls_enable;
    logic [31:0] addr;
    logic [31:0] store_val;
    logic [3:0]  lsb_type;
    logic        ls_finished;
    logic [31:0] load_val;

    // fetch side
    logic        if_enable;
    logic [31:0] if_addr;
    logic        if_finished;
    logic [31:0] if_inst;

    // RAM side
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  ls_enable, addr, store_val, lsb_type,
        output ls_finished, load_val,
        input  if_enable, if_addr,
        output if_finished, if_inst,
        input  mem_din, io_buffer_full,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output ls_enable, addr, store_val, lsb_type,
        input  ls_finished, load_val,
        output if_enable, if_addr,
        input  if_finished, if_inst,
        output mem_din, io_buffer_full,
        input  mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl_load_ext.sv
// -----------------------------------------------------------------------------
// load_ext
// Combinational load-result extension.
//   ls_type : access type (LB/LH/LW/LBU/LHU)
//   raw     : little-endian assembled bytes, byte 0 in raw[7:0]
//   ext     : sign- or zero-extended result; full word for LW and anything else
// -----------------------------------------------------------------------------
module load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [3:0]  ls_type,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        case (ls_type)
            LS_LB:   ext = {{24{raw[7]}},  raw[7:0]};
            LS_LH:   ext = {{16{raw[15]}}, raw[15:0]};
            LS_LBU:  ext = {24'b0, raw[7:0]};
            LS_LHU:  ext = {16'b0, raw[15:0]};
            LS_LW:   ext = raw;
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Byte-serial memory controller shared by the LSB and the instruction fetch
// unit. One access at a time, LSB wins a tie, all outputs registered.
//
// Ports
//   clk_in  : system clock
//   rst_in  : asynchronous active-high reset
//   rdy_in  : global ready; low freezes the block (write strobe dropped)
//   clear   : pipeline flush; aborts loads/fetches, stores run to completion
//   bus     : mem_ctrl_if.slave (LSB request, fetch request, RAM port)
//
// Timing (E0 = accept edge, N = bytes)
//   LOAD/FETCH : mem_a=base+k after E_k, mem_din of byte k taken at E_{k+2},
//                done pulse + result at E_{N+1}
//   STORE      : byte k on the bus with mem_wr=1 after E_k, done at E_N
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    input  logic      clear,
    mem_ctrl_if.slave bus
);

    state_e      state;
    logic [2:0]  cnt;      // LOAD/FETCH: edges since accept; STORE: byte index on the bus
    logic [2:0]  nbytes;
    logic [3:0]  ltype;
    logic [31:0] sdata;
    logic [31:0] rbuf;     // load assembly buffer
    logic        io_st;    // current store targets IO space
    logic        wr_done;  // byte on the bus was written during an rdy_in stall

    logic [31:0] raw;
    logic [31:0] ext_val;
    logic        can_acc;
    logic        st_written;
    logic        st_last;
    logic [2:0]  st_idx;

    // Assembly buffer with the byte arriving this cycle merged in. Byte k
    // arrives when cnt == k+2, so the final byte is folded in on the done edge.
    always_comb begin
        raw = rbuf;
        case (cnt)
            3'd2:    raw[7:0]   = bus.mem_din;
            3'd3:    raw[15:8]  = bus.mem_din;
            3'd4:    raw[23:16] = bus.mem_din;
            3'd5:    raw[31:24] = bus.mem_din;
            default: ;
        endcase
    end

    load_ext u_ext (
        .ls_type (ltype),
        .raw     (raw),
        .ext     (ext_val)
    );

    // No acceptance in a done-pulse cycle (requester drops its enable) or
    // while the pipeline is being flushed.
    assign can_acc    = !bus.ls_finished && !bus.if_finished && !clear;

    // A store byte counts as written once mem_wr has been high for a cycle;
    // a byte held back by the IO buffer stays on the bus with mem_wr low.
    assign st_written = bus.mem_wr | wr_done;
    assign st_last    = st_written && ((cnt + 3'd1) == nbytes);
    assign st_idx     = st_written ? cnt + 3'd1 : cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            nbytes          <= '0;
            ltype           <= '0;
            sdata           <= '0;
            rbuf            <= '0;
            io_st           <= 1'b0;
            wr_done         <= 1'b0;
            bus.mem_a       <= '0;
            bus.mem_dout    <= '0;
            bus.mem_wr      <= 1'b0;
            bus.ls_finished <= 1'b0;
            bus.if_finished <= 1'b0;
            bus.load_val    <= '0;
            bus.if_inst     <= '0;
        end else if (!rdy_in) begin
            // Frozen. The RAM still sees the strobe at this edge, so the byte
            // is remembered as written and the strobe drops to avoid repeats.
            bus.mem_wr <= 1'b0;
            if (state == ST_STORE && bus.mem_wr)
                wr_done <= 1'b1;
        end else begin
            bus.ls_finished <= 1'b0;
            bus.if_finished <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (can_acc && bus.ls_enable) begin
                        bus.mem_a <= bus.addr;
                        nbytes    <= ls_bytes(bus.lsb_type);
                        ltype     <= bus.lsb_type;
                        rbuf      <= '0;
                        wr_done   <= 1'b0;
                        if (bus.lsb_type[3]) begin
                            state        <= ST_STORE;
                            cnt          <= 3'd0;
                            sdata        <= bus.store_val;
                            io_st        <= is_io(bus.addr);
                            bus.mem_dout <= bus.store_val[7:0];
                            bus.mem_wr   <= !(is_io(bus.addr) && bus.io_buffer_full);
                        end else begin
                            state      <= ST_LOAD;
                            cnt        <= 3'd1;
                            bus.mem_wr <= 1'b0;
                        end
                    end else if (can_acc && bus.if_enable) begin
                        state      <= ST_FETCH;
                        cnt        <= 3'd1;
                        nbytes     <= 3'd4;
                        rbuf       <= '0;
                        bus.mem_a  <= bus.if_addr;
                        bus.mem_wr <= 1'b0;
                    end
                end

                ST_LOAD, ST_FETCH: begin
                    if (clear) begin
                        state      <= ST_IDLE;
                        bus.mem_wr <= 1'b0;
                    end else if (cnt == nbytes + 3'd1) begin
                        state <= ST_IDLE;
                        if (state == ST_LOAD) begin
                            bus.ls_finished <= 1'b1;
                            bus.load_val    <= ext_val;
                        end else begin
                            bus.if_finished <= 1'b1;
                            bus.if_inst     <= raw;
                        end
                    end else begin
                        if (cnt < nbytes)
                            bus.mem_a <= bus.mem_a + 32'd1;
                        rbuf <= raw;
                        cnt  <= cnt + 3'd1;
                    end
                end

                // Stores ignore clear: once accepted they are committed.
                ST_STORE: begin
                    if (st_last) begin
                        state           <= ST_IDLE;
                        bus.ls_finished <= 1'b1;
                        bus.load_val    <= '0;
                        bus.mem_wr      <= 1'b0;
                        wr_done         <= 1'b0;
                    end else begin
                        cnt          <= st_idx;
                        if (st_written)
                            bus.mem_a <= bus.mem_a + 32'd1;
                        bus.mem_dout <= sdata[{st_idx[1:0], 3'b000} +: 8];
                        bus.mem_wr   <= !(io_st && bus.io_buffer_full);
                        wr_done      <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Directed bench for mem_ctrl: byte RAM with one-cycle read latency, a write
// log, done-pulse monitors, and hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic clear;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clear  (clear),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // RAM model (addresses alias modulo 256 KiB)
    logic [7:0]  ram [0:262143];
    logic        pk_en;
    logic [17:0] pk_a;
    logic [7:0]  pk_d;
    logic [31:0] wa_q [$];
    logic [7:0]  wd_q [$];

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        bus.mem_din <= ram[bus.mem_a[17:0]];
        if (pk_en) ram[pk_a] <= pk_d;
        if (bus.mem_wr) begin
            ram[bus.mem_a[17:0]] <= bus.mem_dout;
            wa_q.push_back(bus.mem_a);
            wd_q.push_back(bus.mem_dout);
        end
    end

    // Done-pulse monitors
    int          ls_n = 0, if_n = 0, ls_at = 0, if_at = 0;
    logic [31:0] ls_v = '0, if_v = '0;

    always @(negedge clk_in) begin
        if (bus.ls_finished) begin
            ls_n  <= ls_n + 1;
            ls_at <= cyc;
            ls_v  <= bus.load_val;
        end
        if (bus.if_finished) begin
            if_n  <= if_n + 1;
            if_at <= cyc;
            if_v  <= bus.if_inst;
        end
    end

    int ls_b, if_b, wn0, e0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk_in);
        pk_en = 1'b1; pk_a = a[17:0]; pk_d = d;
        @(negedge clk_in);
        pk_en = 1'b0;
    endtask

    task automatic poke32(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) poke(a + 32'(i), w[8*i +: 8]);
    endtask

    // Issue one LSB request; returns just after the accept edge E0.
    task automatic lsb_req(input logic [3:0] t, input logic [31:0] a, input logic [31:0] sv);
        ls_b = ls_n; if_b = if_n; wn0 = wa_q.size();
        @(negedge clk_in);
        bus.ls_enable = 1'b1; bus.lsb_type = t; bus.addr = a; bus.store_val = sv;
        @(posedge clk_in); #1;
        e0 = cyc;
        bus.ls_enable = 1'b0;
    endtask

    task automatic wait_ls();
        for (int i = 0; i < 30 && !bus.ls_finished; i++) @(negedge clk_in);
        repeat (3) @(negedge clk_in);
    endtask

    task automatic load_chk(input string tag, input logic [3:0] t, input logic [31:0] a,
                            input logic [31:0] exp, input int lat);
        lsb_req(t, a, 32'h0);
        wait_ls();
        chk({tag, ".val"}, ls_v, exp);
        chk({tag, ".lat"}, ls_at - e0, lat);
        chk({tag, ".pulses"}, ls_n - ls_b, 1);
    endtask

    task automatic wr_chk(input string tag, input int idx, input logic [31:0] a, input logic [7:0] d);
        chk({tag, ".addr"}, wa_q[wn0 + idx], a);
        chk({tag, ".data"}, 32'(wd_q[wn0 + idx]), 32'(d));
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; pk_en = 1'b0; pk_a = '0; pk_d = '0;
        bus.ls_enable = 1'b0; bus.addr = '0; bus.store_val = '0; bus.lsb_type = LS_LB;
        bus.if_enable = 1'b0; bus.if_addr = '0; bus.io_buffer_full = 1'b0;
        #2 rst_in = 1'b1;

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("rst.mem_a", bus.mem_a, 32'h0);
        chk("rst.mem_dout", 32'(bus.mem_dout), 32'h0);
        chk("rst.mem_wr", 32'(bus.mem_wr), 32'h0);
        chk("rst.ls_fin", 32'(bus.ls_finished), 32'h0);
        chk("rst.if_fin", 32'(bus.if_finished), 32'h0);
        chk("rst.load_val", bus.load_val, 32'h0);
        chk("rst.if_inst", bus.if_inst, 32'h0);
        rst_in = 1'b0;

        // Memory image
        poke32(32'h1000, 32'h12345678);
        poke32(32'h2000, 32'h80AA0000);
        poke(32'h2004, 8'h7F);
        poke32(32'h4000, 32'h44332211);
        poke32(32'h5000, 32'h00000013);
        poke(32'h3FFFE, 8'hAA); poke(32'h3FFFF, 8'hBB);
        poke(32'h0, 8'hCC);     poke(32'h1, 8'hDD);

        // Loads: word, bytes, halves (misaligned), address wrap
        load_chk("lw", LS_LW, 32'h1000, 32'h12345678, 5);
        load_chk("lb", LS_LB, 32'h2003, 32'hFFFFFF80, 2);
        load_chk("lbu", LS_LBU, 32'h2003, 32'h00000080, 2);
        load_chk("lh", LS_LH, 32'h2002, 32'hFFFF80AA, 3);
        load_chk("lhu", LS_LHU, 32'h2002, 32'h000080AA, 3);
        load_chk("lh_mis", LS_LH, 32'h2003, 32'h00007F80, 3);
        load_chk("lw_wrap", LS_LW, 32'hFFFFFFFE, 32'hDDCCBBAA, 5);

        // SH: EF then BE, done at E2, strobe low afterwards, load_val zeroed
        lsb_req(LS_SH, 32'h3000, 32'hDEADBEEF);
        wait_ls();
        chk("sh.nwr", wa_q.size() - wn0, 2);
        wr_chk("sh.b0", 0, 32'h3000, 8'hEF);
        wr_chk("sh.b1", 1, 32'h3001, 8'hBE);
        chk("sh.lat", ls_at - e0, 2);
        chk("sh.pulses", ls_n - ls_b, 1);
        chk("sh.mem_wr", 32'(bus.mem_wr), 32'h0);
        chk("sh.load_val", ls_v, 32'h0);

        // LW and fetch together: LW first, fetch after turnaround (E7 -> E12)
        ls_b = ls_n; if_b = if_n;
        @(negedge clk_in);
        bus.ls_enable = 1'b1; bus.lsb_type = LS_LW; bus.addr = 32'h4000;
        bus.if_enable = 1'b1; bus.if_addr = 32'h5000;
        @(posedge clk_in); #1;
        e0 = cyc;
        bus.ls_enable = 1'b0;
        for (int i = 0; i < 40 && !bus.if_finished; i++) @(negedge clk_in);
        bus.if_enable = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("both.ls_val", ls_v, 32'h44332211);
        chk("both.ls_lat", ls_at - e0, 5);
        chk("both.if_inst", if_v, 32'h00000013);
        chk("both.if_lat", if_at - e0, 12);
        chk("both.if_pulses", if_n - if_b, 1);
        chk("both.ls_pulses", ls_n - ls_b, 1);

        // SB to IO space with the buffer full for E0..E2
        bus.io_buffer_full = 1'b1;
        lsb_req(LS_SB, 32'h00030000, 32'h0000005A);
        @(posedge clk_in); @(posedge clk_in);
        @(negedge clk_in);
        chk("io.nwr_held", wa_q.size() - wn0, 0);
        bus.io_buffer_full = 1'b0;
        wait_ls();
        chk("io.nwr", wa_q.size() - wn0, 1);
        wr_chk("io.b0", 0, 32'h00030000, 8'h5A);
        chk("io.lat", ls_at - e0, 4);

        // clear in the second cycle of a fetch, then an LW the very next cycle
        if_b = if_n;
        @(negedge clk_in);
        bus.if_enable = 1'b1; bus.if_addr = 32'h5000;
        @(posedge clk_in); #1;
        bus.if_enable = 1'b0;
        @(negedge clk_in);
        clear = 1'b1;
        @(posedge clk_in); #1;
        clear = 1'b0;
        chk("clr.mem_wr", 32'(bus.mem_wr), 32'h0);
        lsb_req(LS_LW, 32'h1000, 32'h0);
        wait_ls();
        chk("clr.if_pulses", if_n - if_b, 0);
        chk("clr.lw_lat", ls_at - e0, 5);
        chk("clr.lw_val", ls_v, 32'h12345678);

        // clear mid-SW: all four bytes still go out
        lsb_req(LS_SW, 32'h7000, 32'h01020304);
        @(posedge clk_in);
        @(negedge clk_in);
        clear = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;
        wait_ls();
        chk("sw_clr.nwr", wa_q.size() - wn0, 4);
        wr_chk("sw_clr.b0", 0, 32'h7000, 8'h04);
        wr_chk("sw_clr.b3", 3, 32'h7003, 8'h01);
        chk("sw_clr.lat", ls_at - e0, 4);

        // rdy_in low across E1/E2 of an SH: no byte written twice
        lsb_req(LS_SH, 32'h9000, 32'h0000CAFE);
        @(negedge clk_in);
        rdy_in = 1'b0;
        @(posedge clk_in); @(posedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b1;
        wait_ls();
        chk("stall.nwr", wa_q.size() - wn0, 2);
        wr_chk("stall.b0", 0, 32'h9000, 8'hFE);
        wr_chk("stall.b1", 1, 32'h9001, 8'hCA);
        chk("stall.lat", ls_at - e0, 4);

        // Reset after the first byte of an SW: rest dropped, no pulse
        lsb_req(LS_SW, 32'h8000, 32'h11223344);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (8) @(negedge clk_in);
        chk("rst_sw.nwr", wa_q.size() - wn0, 1);
        chk("rst_sw.pulses", ls_n - ls_b, 0);
        chk("rst_sw.mem_wr", 32'(bus.mem_wr), 32'h0);
        chk("rst_sw.mem_a", bus.mem_a, 32'h0);
        load_chk("post_rst", LS_LW, 32'h1000, 32'h12345678, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports clk_in (in, 1, system clock), rst_in (in, 1, reset), rdy_in (in, 1, stall when low), clear (in, 1, pipeline flush); one clock, reset asynchronous and active-high.
REQ-002 SHALL have LSB side: ls_enable in 1 request; addr in 32; store_val in 32; lsb_type in 4 (LB/LH/LW/LBU/LHU/SB/SH/SW); ls_finished out 1 done pulse; load_val out 32 result.
REQ-003 SHALL have fetch side: if_enable in 1 request; if_addr in 32; if_finished out 1 done pulse; if_inst out 32 instruction word.
REQ-004 SHALL have RAM side: mem_din in 8 read byte; mem_dout out 8 write byte; mem_a out 32 byte address; mem_wr out 1 (1=write); io_buffer_full in 1 UART back-pressure.

Function
REQ-005 SHALL use states IDLE, LOAD, STORE, FETCH, with all outputs registered.
REQ-006 SHALL accept a request only in IDLE; LSB request has priority over fetch when both are asserted at the same edge.
REQ-007 SHALL size the access from lsb_type[1:0]: 00 gives 1 byte, 01 gives 2, 10 gives 4; fetch is always 4 bytes; lsb_type[3]=1 selects STORE.
REQ-008 SHALL, on the accept edge E0, load mem_a with the base address; byte k SHALL be addressed at base+k, little-endian.
REQ-009 LOAD/FETCH: mem_a=base+k is driven after edge E_k with mem_wr=0; mem_din is sampled at edge E_{k+2} (one-cycle RAM read latency).
REQ-010 LOAD/FETCH: at edge E_{N+1} the block SHALL set the done pulse and result, then return to IDLE.
REQ-011 STORE: mem_a=base+k, mem_dout=store_val[8k+7:8k] and mem_wr=1 are driven after E_k; at E_N the block SHALL set ls_finished=1 and mem_wr=0, then return to IDLE.
REQ-012 SHALL sign-extend LB/LH and zero-extend LBU/LHU; LW/fetch SHALL return all 32 bits. load_val for stores SHALL be 0.
REQ-013 ls_finished/if_finished SHALL be high for exactly one cycle; no request is accepted in the pulse cycle (one-cycle turnaround so the requester can drop its enable).
REQ-014 STORE to the IO space (addr[17:16]==2'b11) while io_buffer_full=1 SHALL hold the current byte with mem_wr=0 and no progress until io_buffer_full=0.
REQ-015 clear with rdy_in=1 SHALL abort LOAD/FETCH to IDLE with no done pulse and mem_wr=0; a STORE in progress SHALL complete and pulse ls_finished, because it is already committed.
REQ-016 rdy_in=0 SHALL freeze all state and outputs, except that mem_wr SHALL be forced to 0 the following cycle so no byte is written twice.
REQ-017 Address arithmetic SHALL be 32-bit wrap-around; misaligned addresses SHALL be accepted and accessed bytewise.

Reset
REQ-018 rst_in SHALL immediately force IDLE and set mem_a=0, mem_dout=0, mem_wr=0, ls_finished=0, if_finished=0, load_val=0, if_inst=0, with the byte counter and assembly buffer cleared.
REQ-019 Reset in the middle of a STORE SHALL drop the remaining bytes; no done pulse SHALL follow deassertion.

Structure
REQ-020 The access-type encodings (LB=0000 ... SW=1010) and the IO address-space constant SHALL live in the shared defines package used by lsb and the decoder.
REQ-021 Load extension SHALL be a combinational sub-module load_ext (type, raw 32-bit word to extended value); everything else SHALL stay in one FSM.

Verification
REQ-022 LW at 0x1000 with RAM bytes 78 56 34 12: load_val=0x12345678, ls_finished one cycle, 5 cycles after acceptance.
REQ-023 LB at 0x2003 with byte 0x80: load_val=0xFFFFFF80; LBU with the same byte: 0x00000080.
REQ-024 SH at 0x3000 with store_val=0xDEADBEEF: writes EF then BE to 0x3000/0x3001, mem_wr low afterwards, ls_finished at E2.
REQ-025 ls_enable (LW) and if_enable asserted together: LSB is served first; the fetch is accepted after the turnaround, and if_inst shows the correct word.
REQ-026 SB to 0x30000 with io_buffer_full high for 3 cycles: no write while high; exactly one write of the byte afterwards.
REQ-027 clear in the second cycle of a FETCH: no if_finished pulse, IDLE next cycle. clear mid-SW: all 4 bytes are written, then ls_finished.
